usr_shift_sequencer: RTL and testbench

- Command-driven sequencer for a universal shift register (USR) datapath.
- Accepts one command per handshake: parallel-load word, shift direction and shift count.
- Steps the USR mode select through LOAD, then N SHIFT cycles, then HOLD, and pulses done.
- Sits between a host/command source and the USR. Used for bit-serial alignment and barrel-style shifting of small words.

---
 rtl/usr_pkg.sv | 17 +
 rtl/usr_seq_core.sv | 29 ++
 rtl/usr_shift_sequencer.sv | 118 +++++++++++
 tb/tb_usr_shift_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register sequencer: mode-select
// encodings and the sequencer FSM state type.
package usr_pkg;

    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHR  = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } usr_seq_state_t;

endpackage

// File: rtl/usr_seq_core.sv
// WIDTH-bit universal shift register: hold, shift right, shift left or
// parallel load according to sel, with a single fill bit for shifts.
module usr_seq_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic             fill,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else begin
            case (sel)
                USR_SHR:  data <= {fill, data[WIDTH-1:1]};
                USR_SHL:  data <= {data[WIDTH-2:0], fill};
                USR_LOAD: data <= load_data;
                default:  data <= data;
            endcase
        end
    end

endmodule

// File: rtl/usr_shift_sequencer.sv
// Command-driven sequencer stepping a USR through LOAD, cnt SHIFT cycles and
// a DONE pulse. Optional rotate mode via `define USR_SEQ_ROTATE_EN.
module usr_shift_sequencer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             ser_in,
`ifdef USR_SEQ_ROTATE_EN
    input  logic             cmd_rot,
`endif
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);

    usr_seq_state_t state;
    usr_seq_state_t state_next;

    logic [WIDTH-1:0] data_lat;
    logic             dir_lat;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             fill;

    // Ready is masked while rst is held so nothing is accepted in the reset cycle.
    assign cmd_ready = (state == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

`ifdef USR_SEQ_ROTATE_EN
    logic rot_lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            rot_lat <= 1'b0;
        end else if (accept) begin
            rot_lat <= cmd_rot;
        end
    end

    // Rotate recirculates the bit falling off the end being shifted away from.
    assign fill = rot_lat ? (dir_lat ? data_out[WIDTH-1] : data_out[0]) : ser_in;
`else
    assign fill = ser_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dir_lat <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                dir_lat <= cmd_dir;
                cnt     <= cmd_cnt;
            end else if (state == SHIFT) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_lat <= cmd_data;
        end
    end

    always_comb begin
        state_next = state;
        sel        = USR_HOLD;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = LOAD;
            end
            LOAD: begin
                sel        = USR_LOAD;
                busy       = 1'b1;
                state_next = (cnt != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                sel  = dir_lat ? USR_SHL : USR_SHR;
                busy = 1'b1;
                // Counter holds the shifts still to perform including this one.
                if (cnt == CNT_W'(1)) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    usr_seq_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .fill     (fill),
        .load_data(data_lat),
        .data     (data_out)
    );

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed self-checking bench for usr_shift_sequencer (WIDTH=4, CNT_W=3),
// with a cycle-level command model compared every cycle.
module tb_usr_shift_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             cmd_dir = 1'b0;
    logic [CNT_W-1:0] cmd_cnt = '0;
    logic             ser_in = 1'b0;
    logic             cmd_rot = 1'b0;
    logic [1:0]       sel;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;

    int n_cmp  = 0;
    int n_fail = 0;
    logic check_en = 1'b0;

    usr_shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data (cmd_data),
        .cmd_dir  (cmd_dir),
        .cmd_cnt  (cmd_cnt),
        .ser_in   (ser_in),
`ifdef USR_SEQ_ROTATE_EN
        .cmd_rot  (cmd_rot),
`endif
        .sel      (sel),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Model: phase = cycles elapsed since accept (0 = idle); phase 1 loads,
    // phases 2..cnt+1 shift, phase cnt+2 is the done cycle.
    int       m_phase = 0;
    int       m_cnt   = 0;
    int       m_dir   = 0;
    int       m_rot   = 0;
    int       m_lat   = 0;
    int       m_data  = 0;

    always @(posedge clk) begin
        int fb;
        if (rst) begin
            m_phase = 0;
            m_data  = 0;
        end else if (m_phase == 0) begin
            if (cmd_valid) begin
                m_lat   = int'(cmd_data);
                m_dir   = int'(cmd_dir);
                m_cnt   = int'(cmd_cnt);
`ifdef USR_SEQ_ROTATE_EN
                m_rot   = int'(cmd_rot);
`else
                m_rot   = 0;
`endif
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_data  = m_lat;
            m_phase = 2;
        end else if (m_phase <= m_cnt + 1) begin
            if (m_dir == 1) begin
                fb     = (m_rot == 1) ? (m_data / 8) % 2 : int'(ser_in);
                m_data = (m_data * 2 + fb) % 16;
            end else begin
                fb     = (m_rot == 1) ? m_data % 2 : int'(ser_in);
                m_data = m_data / 2 + fb * 8;
            end
            m_phase = m_phase + 1;
        end else begin
            m_phase = 0;
        end
    end

    function automatic int exp_sel();
        if (m_phase == 0 || m_phase == m_cnt + 2) return 0;
        if (m_phase == 1) return 3;
        return (m_dir == 1) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("model_sel", 32'(sel), 32'(exp_sel()));
            check("model_busy", 32'(busy), 32'(m_phase != 0));
            check("model_done", 32'(done), 32'(m_phase != 0 && m_phase == m_cnt + 2));
            check("model_ready", 32'(cmd_ready), 32'(m_phase == 0 && !rst));
            check("model_data", 32'(data_out), 32'(m_data));
        end
    end

    task automatic wait_ready(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issues one command, returns accept-to-done latency, sel trace and final data.
    task automatic run_cmd(input logic [3:0] d, input logic dir, input logic [2:0] cnt,
                           input logic s, input logic rot,
                           output int lat, output logic [31:0] seq, output logic [3:0] fin);
        logic ok;
        cmd_data = d; cmd_dir = dir; cmd_cnt = cnt; ser_in = s; cmd_rot = rot;
        cmd_valid = 1'b1;
        wait_ready(ok);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0; seq = '0; fin = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            seq = {seq[29:0], sel};
            if (done) begin
                fin = data_out;
                break;
            end
        end
        if (lat >= 20) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    int          lat;
    logic [31:0] seq;
    logic [3:0]  fin;
    int          done_seen;
    logic        ok;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        check_en = 1'b1;
        @(negedge clk);
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ready", 32'(cmd_ready), 32'd0);
        check("reset_data", 32'(data_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Right shift by one, zero fill.
        run_cmd(4'b1011, 1'b0, 3'd1, 1'b0, 1'b0, lat, seq, fin);
        check("t1_data", 32'(fin), 32'h5);
        check("t1_lat", 32'(lat), 32'd3);
        check("t1_seq", seq, 32'b11_01_00);

        // Left shift by two, one fill.
        run_cmd(4'b1011, 1'b1, 3'd2, 1'b1, 1'b0, lat, seq, fin);
        check("t2_data", 32'(fin), 32'hF);
        check("t2_lat", 32'(lat), 32'd4);
        check("t2_seq", seq, 32'b11_10_10_00);

        // Load only.
        run_cmd(4'b0110, 1'b0, 3'd0, 1'b1, 1'b0, lat, seq, fin);
        check("t3_data", 32'(fin), 32'h6);
        check("t3_lat", 32'(lat), 32'd2);
        check("t3_seq", seq, 32'b11_00);

        // Count beyond width: word fully replaced by serial ones.
        run_cmd(4'b0000, 1'b0, 3'd7, 1'b1, 1'b0, lat, seq, fin);
        check("t3b_data", 32'(fin), 32'hF);
        check("t3b_lat", 32'(lat), 32'd9);

        // Held cmd_valid with a different word while busy is ignored.
        cmd_data = 4'b1011; cmd_dir = 1'b0; cmd_cnt = 3'd1; ser_in = 1'b0; cmd_rot = 1'b0;
        cmd_valid = 1'b1;
        wait_ready(ok);
        @(posedge clk); #1;
        cmd_data = 4'b0011; cmd_dir = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 20 && done_seen == 0; i++) begin
            @(negedge clk);
            check("t4_hold_busy_ready", 32'(cmd_ready), 32'd0);
            if (done) begin
                done_seen = 1;
                check("t4_first_data", 32'(data_out), 32'h5);
            end
        end
        check("t4_first_done", 32'(done_seen), 32'd1);
        @(negedge clk);
        check("t4_idle_ready", 32'(cmd_ready), 32'd1);
        check("t4_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t4_second_load", 32'(sel), 32'd3);
        done_seen = 0;
        for (int i = 0; i < 20 && done_seen == 0; i++) begin
            @(negedge clk);
            if (done) begin
                done_seen = 1;
                check("t4_second_data", 32'(data_out), 32'h6);
            end
        end
        check("t4_second_done", 32'(done_seen), 32'd1);
        @(posedge clk); #1;

        // Reset during the second shift cycle of a cnt=5 command.
        cmd_data = 4'b1011; cmd_dir = 1'b0; cmd_cnt = 3'd5; ser_in = 1'b1;
        cmd_valid = 1'b1;
        wait_ready(ok);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t5_in_shift", 32'(sel), 32'd1);
        @(negedge clk);
        check("t5_rst_data", 32'(data_out), 32'd0);
        check("t5_rst_sel", 32'(sel), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("t5_no_done", 32'(done_seen), 32'd0);
        run_cmd(4'b1011, 1'b0, 3'd1, 1'b0, 1'b0, lat, seq, fin);
        check("t5_after_data", 32'(fin), 32'h5);
        check("t5_after_lat", 32'(lat), 32'd3);

`ifdef USR_SEQ_ROTATE_EN
        run_cmd(4'b1011, 1'b0, 3'd1, 1'b0, 1'b1, lat, seq, fin);
        check("rot1_data", 32'(fin), 32'hD);
        run_cmd(4'b1011, 1'b0, 3'd4, 1'b0, 1'b1, lat, seq, fin);
        check("rot4_data", 32'(fin), 32'hB);
        run_cmd(4'b1000, 1'b1, 3'd1, 1'b0, 1'b1, lat, seq, fin);
        check("rotl_data", 32'(fin), 32'h1);
`endif

        repeat (2) @(negedge clk);
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
